// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with an optional return-address stack.
//
// Word-addressed program counter. The next address is chosen from sequential
// (+1), absolute jump, register jump, conditional branch and return targets.
// pc_addr changes only on an advance cycle: load_instr high with neither stall
// asserted. A cache stall freezes everything.
//
// Build option: define PC_RAS_EN to build the return-address stack. Without it
// there is no stack storage, ret acts as a register jump, call is ignored, and
// the stack status outputs are tied off.
//
// Ports:
//   clk, rst_                 clock, asynchronous active-low reset
//   pc_addr                   current instruction address (registered)
//   cache_stall, stall_pipe   freeze all state
//   load_instr                advance enable
//   jmp, addr                 absolute jump and its target field
//   jreg, r1_data             register jump and its target value
//   breq/equal, brne/not_equal, sign_ext_imm   conditional branch controls
//   call, ret                 push link address / pop and redirect
//   ras_empty, ras_full       stack occupancy status
//   ras_ovf                   sticky: a push happened while full
//   ras_miss                  one-cycle pulse after a ret taken on an empty stack
module pc_ras #(
  parameter int unsigned     BITS       = 32,
  parameter int unsigned     RAS_DEPTH  = 4,
  parameter logic [BITS-1:0] RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst_,
  output logic [BITS-1:0] pc_addr,
  input  logic            cache_stall,
  input  logic            stall_pipe,
  input  logic            load_instr,
  input  logic            jmp,
  input  logic [BITS-7:0] addr,
  input  logic            jreg,
  input  logic [BITS-1:0] r1_data,
  input  logic            breq,
  input  logic            equal,
  input  logic            brne,
  input  logic            not_equal,
  input  logic [BITS-1:0] sign_ext_imm,
  input  logic            call,
  input  logic            ret,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_miss
);

  logic [BITS-1:0] pc_q, pc_d;
  logic [BITS-1:0] p1, jump_t, branch_t, ret_tgt;
  logic            adv, take_br;

  assign adv      = load_instr && !stall_pipe && !cache_stall;
  assign p1       = pc_q + BITS'(1);
  assign jump_t   = {pc_q[BITS-1:BITS-4], 2'b00, addr};
  assign branch_t = pc_q + sign_ext_imm;
  assign take_br  = (breq && equal) || (brne && not_equal);

  always_comb begin
    pc_d = p1;
    if (ret)          pc_d = ret_tgt;
    else if (jreg)    pc_d = r1_data;
    else if (jmp)     pc_d = jump_t;
    else if (take_br) pc_d = branch_t;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)    pc_q <= RESET_ADDR;
    else if (adv) pc_q <= pc_d;
  end

  assign pc_addr = pc_q;

`ifdef PC_RAS_EN
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RAS_DEPTH - 1);

  // sp_q is the next free slot; the top entry sits one below it (circularly).
  logic [BITS-1:0] stack_q [RAS_DEPTH];
  logic [PW-1:0]   sp_q, sp_d, top_idx, wr_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d, miss_q, miss_d;
  logic            empty, push, pop;

  assign empty   = (cnt_q == '0);
  assign top_idx = (sp_q == '0) ? LAST_C : sp_q - PW'(1);
  assign ret_tgt = empty ? r1_data : stack_q[top_idx];
  assign push    = adv && call && (jmp || jreg || ret);
  assign pop     = adv && ret && !empty;
  // Pop-then-push collapses to overwriting the current top in place.
  assign wr_idx  = pop ? top_idx : sp_q;

  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    miss_d = adv && ret && empty;
    if (push && !pop) begin
      sp_d = (sp_q == LAST_C) ? '0 : sp_q + PW'(1);
      // Pushing while full overwrites the oldest slot; the count saturates.
      if (cnt_q == DEPTH_C) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      miss_q <= miss_d;
    end
  end

  // Entries are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[wr_idx] <= p1;
  end

  assign ras_empty = empty;
  assign ras_full  = (cnt_q == DEPTH_C);
  assign ras_ovf   = ovf_q;
  assign ras_miss  = miss_q;
`else
  logic unused_call;

  assign unused_call = call;
  assign ret_tgt     = r1_data;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
  assign ras_ovf     = 1'b0;
  assign ras_miss    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ras.sv
module tb_pc_ras;
  localparam int          BITS  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_A = 32'h0;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [31:0] pc_addr;
  logic        cache_stall, stall_pipe, load_instr, jmp, jreg;
  logic [25:0] addr;
  logic [31:0] r1_data, sign_ext_imm;
  logic        breq, equal, brne, not_equal, call, ret;
  logic        ras_empty, ras_full, ras_ovf, ras_miss;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the stack is a queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_ovf, m_miss;

  pc_ras #(.BITS(BITS), .RAS_DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clk(clk), .rst_(rst_), .pc_addr(pc_addr),
    .cache_stall(cache_stall), .stall_pipe(stall_pipe), .load_instr(load_instr),
    .jmp(jmp), .addr(addr), .jreg(jreg), .r1_data(r1_data),
    .breq(breq), .equal(equal), .brne(brne), .not_equal(not_equal),
    .sign_ext_imm(sign_ext_imm), .call(call), .ret(ret),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_miss(ras_miss)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_empty();
    return RAS_EN ? (m_q.size() == 0) : 1'b1;
  endfunction

  function automatic bit m_full();
    return RAS_EN ? (m_q.size() == DEPTH) : 1'b0;
  endfunction

  task automatic idle();
    cache_stall = 0; stall_pipe = 0; load_instr = 0; jmp = 0; jreg = 0;
    addr = '0; r1_data = '0; breq = 0; equal = 0; brne = 0; not_equal = 0;
    sign_ext_imm = '0; call = 0; ret = 0;
  endtask

  task automatic model_reset();
    m_pc = RST_A;
    m_q.delete();
    m_ovf = 0;
    m_miss = 0;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    model_reset();
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  // Apply the model to the current inputs, then take one clock edge.
  task automatic cycle();
    logic [31:0] p1, nxt;
    bit adv;
    p1 = m_pc + 32'd1;
    adv = load_instr && !stall_pipe && !cache_stall;
    m_miss = 0;
    if (adv) begin
      if (ret)       nxt = (RAS_EN && m_q.size() > 0) ? m_q[$] : r1_data;
      else if (jreg) nxt = r1_data;
      else if (jmp)  nxt = {m_pc[31:28], 2'b00, addr};
      else if ((breq && equal) || (brne && not_equal)) nxt = m_pc + sign_ext_imm;
      else           nxt = p1;
      if (RAS_EN) begin
        if (ret && m_q.size() == 0) m_miss = 1;
        if (ret && m_q.size() > 0) void'(m_q.pop_back());
        if (call && (jmp || jreg || ret)) begin
          if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1;
          end
          m_q.push_back(p1);
        end
      end
      m_pc = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    load_instr = 1;
    cycle();
    cycle();
    #2 rst_ = 1'b0;
    #1;
    model_reset();
    n_checks++; if (pc_addr !== RST_A) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_addr, RST_A); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", ras_full); end
    n_checks++; if ({ras_ovf, ras_miss} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf_miss got=%b%b exp=00", ras_ovf, ras_miss); end
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_sequential();
    idle();
    load_instr = 1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      n_checks++; if (pc_addr !== 32'(i)) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc_addr, 32'(i)); end
      n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL seq_empty[%0d] got=%b exp=1", i, ras_empty); end
    end
    load_instr = 0;
    cycle();
    n_checks++; if (pc_addr !== 32'd3) begin n_fail++; $display("FAIL seq_hold got=%h exp=3", pc_addr); end
  endtask

  task automatic test_call_ret();
    idle();
    load_instr = 1;
    jreg = 1; r1_data = 32'h10;
    cycle();
    jreg = 0; jmp = 1; call = 1; addr = 26'h40;
    cycle();
    n_checks++; if (pc_addr !== 32'h40) begin n_fail++; $display("FAIL call_pc got=%h exp=40", pc_addr); end
    n_checks++; if (ras_empty !== !RAS_EN) begin n_fail++; $display("FAIL call_empty got=%b exp=%b", ras_empty, !RAS_EN); end
    jmp = 0; call = 0; ret = 1; r1_data = 32'h99;
    cycle();
    n_checks++; if (pc_addr !== (RAS_EN ? 32'h11 : 32'h99)) begin n_fail++; $display("FAIL ret_pc got=%h exp=%h", pc_addr, RAS_EN ? 32'h11 : 32'h99); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
    n_checks++; if (ras_miss !== 1'b0) begin n_fail++; $display("FAIL ret_nomiss got=%b exp=0", ras_miss); end
  endtask

  task automatic test_nested();
    logic [31:0] exp;
    do_reset();
    idle();
    load_instr = 1;
    for (int i = 1; i <= 5; i++) begin
      jmp = 0; call = 0; jreg = 1; r1_data = 32'(i * 32'h100);
      cycle();
      jreg = 0; jmp = 1; call = 1; addr = 26'h800;
      cycle();
    end
    n_checks++; if (ras_full !== RAS_EN) begin n_fail++; $display("FAIL nest_full got=%b exp=%b", ras_full, RAS_EN); end
    n_checks++; if (ras_ovf !== RAS_EN) begin n_fail++; $display("FAIL nest_ovf got=%b exp=%b", ras_ovf, RAS_EN); end
    jmp = 0; call = 0; ret = 1; r1_data = 32'hDEAD;
    for (int k = 0; k < 4; k++) begin
      cycle();
      exp = RAS_EN ? 32'((5 - k) * 32'h100 + 1) : 32'hDEAD;
      n_checks++; if (pc_addr !== exp) begin n_fail++; $display("FAIL nest_ret[%0d] got=%h exp=%h", k, pc_addr, exp); end
      n_checks++; if (ras_miss !== 1'b0) begin n_fail++; $display("FAIL nest_miss[%0d] got=%b exp=0", k, ras_miss); end
    end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL nest_empty got=%b exp=1", ras_empty); end
    r1_data = 32'hAA;
    cycle();
    n_checks++; if (pc_addr !== 32'hAA) begin n_fail++; $display("FAIL miss_pc got=%h exp=aa", pc_addr); end
    n_checks++; if (ras_miss !== RAS_EN) begin n_fail++; $display("FAIL miss_pulse got=%b exp=%b", ras_miss, RAS_EN); end
    idle();
    cycle();
    n_checks++; if (ras_miss !== 1'b0) begin n_fail++; $display("FAIL miss_clear got=%b exp=0", ras_miss); end
    n_checks++; if (ras_ovf !== RAS_EN) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=%b", ras_ovf, RAS_EN); end
  endtask

  task automatic test_branch_prio();
    idle();
    load_instr = 1;
    jreg = 1; r1_data = 32'h20;
    cycle();
    breq = 1; equal = 1; sign_ext_imm = 32'hFFFF_FFFC; r1_data = 32'h80;
    cycle();
    n_checks++; if (pc_addr !== 32'h80) begin n_fail++; $display("FAIL prio_jreg got=%h exp=80", pc_addr); end
    jreg = 0;
    cycle();
    n_checks++; if (pc_addr !== 32'h7C) begin n_fail++; $display("FAIL breq_taken got=%h exp=7c", pc_addr); end
    breq = 0; equal = 0; brne = 1; not_equal = 1; sign_ext_imm = 32'h8;
    cycle();
    n_checks++; if (pc_addr !== 32'h84) begin n_fail++; $display("FAIL brne_taken got=%h exp=84", pc_addr); end
    brne = 0; breq = 1; equal = 0; not_equal = 1;
    cycle();
    n_checks++; if (pc_addr !== 32'h85) begin n_fail++; $display("FAIL breq_not_taken got=%h exp=85", pc_addr); end
    breq = 0; jmp = 1; addr = 26'h3FF_FFFF;
    cycle();
    n_checks++; if (pc_addr !== 32'h03FF_FFFF) begin n_fail++; $display("FAIL jmp_concat got=%h exp=03ffffff", pc_addr); end
  endtask

  task automatic test_call_ret_same();
    do_reset();
    idle();
    load_instr = 1;
    jreg = 1; r1_data = 32'h54;
    cycle();
    jreg = 0; jmp = 1; call = 1; addr = 26'h200;
    cycle();
    jmp = 0; call = 0; jreg = 1; r1_data = 32'h30;
    cycle();
    jreg = 0; call = 1; ret = 1; r1_data = 32'h77;
    cycle();
    n_checks++; if (pc_addr !== (RAS_EN ? 32'h55 : 32'h77)) begin n_fail++; $display("FAIL cr_pc got=%h exp=%h", pc_addr, RAS_EN ? 32'h55 : 32'h77); end
    n_checks++; if (ras_empty !== !RAS_EN || ras_full !== 1'b0) begin n_fail++; $display("FAIL cr_count got=%b%b exp=%b0", ras_empty, ras_full, !RAS_EN); end
    call = 0;
    cycle();
    n_checks++; if (pc_addr !== (RAS_EN ? 32'h31 : 32'h77)) begin n_fail++; $display("FAIL cr_newtop got=%h exp=%h", pc_addr, RAS_EN ? 32'h31 : 32'h77); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL cr_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_stall();
    do_reset();
    idle();
    load_instr = 1;
    jreg = 1; r1_data = 32'h70;
    cycle();
    jreg = 0; jmp = 1; call = 1; addr = 26'h300;
    cycle();
    jmp = 0; call = 0; ret = 1; r1_data = 32'hBB; cache_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (pc_addr !== 32'h300) begin n_fail++; $display("FAIL cstall_pc[%0d] got=%h exp=300", i, pc_addr); end
      n_checks++; if (ras_empty !== !RAS_EN) begin n_fail++; $display("FAIL cstall_cnt[%0d] got=%b exp=%b", i, ras_empty, !RAS_EN); end
    end
    cache_stall = 0;
    cycle();
    n_checks++; if (pc_addr !== (RAS_EN ? 32'h71 : 32'hBB)) begin n_fail++; $display("FAIL cstall_rel got=%h exp=%h", pc_addr, RAS_EN ? 32'h71 : 32'hBB); end
    n_checks++; if (ras_empty !== 1'b1 || ras_miss !== 1'b0) begin n_fail++; $display("FAIL cstall_pop got=%b%b exp=10", ras_empty, ras_miss); end
    stall_pipe = 1; r1_data = 32'hCC;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++; if (pc_addr !== m_pc || ras_miss !== 1'b0) begin n_fail++; $display("FAIL pstall[%0d] got=%h/%b exp=%h/0", i, pc_addr, ras_miss, m_pc); end
    end
    stall_pipe = 0;
    cycle();
    n_checks++; if (pc_addr !== 32'hCC) begin n_fail++; $display("FAIL pstall_rel got=%h exp=cc", pc_addr); end
    n_checks++; if (ras_miss !== RAS_EN) begin n_fail++; $display("FAIL pstall_miss got=%b exp=%b", ras_miss, RAS_EN); end
  endtask

  task automatic test_random();
    do_reset();
    idle();
    for (int n = 0; n < 600; n++) begin
      cache_stall  = ($urandom_range(0, 99) < 10);
      stall_pipe   = ($urandom_range(0, 99) < 10);
      load_instr   = ($urandom_range(0, 99) < 85);
      ret          = ($urandom_range(0, 99) < 20);
      jreg         = ($urandom_range(0, 99) < 15);
      jmp          = ($urandom_range(0, 99) < 25);
      call         = ($urandom_range(0, 99) < 40);
      breq         = $urandom_range(0, 1);
      equal        = $urandom_range(0, 1);
      brne         = $urandom_range(0, 1);
      not_equal    = $urandom_range(0, 1);
      addr         = 26'($urandom);
      r1_data      = $urandom;
      sign_ext_imm = 32'($signed($urandom_range(0, 511)) - 256);
      cycle();
      n_checks++; if (pc_addr !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, pc_addr, m_pc); end
      n_checks++; if (ras_empty !== m_empty()) begin n_fail++; $display("FAIL rnd_empty[%0d] got=%b exp=%b", n, ras_empty, m_empty()); end
      n_checks++; if (ras_full !== m_full()) begin n_fail++; $display("FAIL rnd_full[%0d] got=%b exp=%b", n, ras_full, m_full()); end
      n_checks++; if (ras_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", n, ras_ovf, m_ovf); end
      n_checks++; if (ras_miss !== m_miss) begin n_fail++; $display("FAIL rnd_miss[%0d] got=%b exp=%b", n, ras_miss, m_miss); end
    end
  endtask

  initial begin
    idle();
    rst_ = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    test_reset();
    test_sequential();
    test_call_ret();
    test_nested();
    test_branch_prio();
    test_call_ret_same();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
